pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline register that generalises the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) of the RISC-V pipeline. It carries an opaque payload bus and a control bus between two stages. It adds a valid/ready handshake for stalls, a synchronous flush for branch and jump kills, and forced-zero control on bubbles so that squashed slots never assert RegWrite or MemWrite. An optional skid buffer breaks the combinational ready path, and a saturating counter reports back-pressure cycles.

---
 rtl/pipe_stage_reg.sv | 124 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline register between two pipeline stages.
// Carries an opaque payload and a control bus with a valid/ready handshake,
// a synchronous flush, forced-zero control on bubbles and a saturating
// back-pressure counter.
// Optional feature macro: PIPE_STAGE_SKID_EN adds a second (skid) entry so
// that in_ready comes straight from a flop instead of depending on out_ready.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == {CNT_W{1'b1}}) begin
            return value;
        end
        return value + 1'b1;
    endfunction

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    logic              xfer_in;
    logic              xfer_out;

    // A flushed cycle never accepts, even if in_ready is high.
    assign xfer_in  = in_valid && in_ready && !flush;
    assign xfer_out = m_valid && out_ready;

    assign out_valid = m_valid;
    assign out_data  = m_data;
    // Squashed slots must never present RegWrite/MemWrite downstream.
    assign out_ctrl  = m_valid ? m_ctrl : '0;

`ifdef PIPE_STAGE_SKID_EN
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;

    // Ready only depends on whether the skid slot is free: no combinational path.
    assign in_ready = !s_valid;

    // Main/skid storage: skid catches the one entry accepted after out_ready drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ctrl  <= '0;
            s_valid <= 1'b0;
            s_data  <= '0;
            s_ctrl  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (xfer_out) begin
            if (s_valid) begin
                // Oldest waiting entry moves up; in_ready was low so no input.
                m_data  <= s_data;
                m_ctrl  <= s_ctrl;
                s_valid <= 1'b0;
            end else if (xfer_in) begin
                m_data <= in_data;
                m_ctrl <= in_ctrl;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (xfer_in) begin
            if (m_valid) begin
                s_valid <= 1'b1;
                s_data  <= in_data;
                s_ctrl  <= in_ctrl;
            end else begin
                m_valid <= 1'b1;
                m_data  <= in_data;
                m_ctrl  <= in_ctrl;
            end
        end
    end
`else
    // Accept whenever the slot is empty or is being drained this same cycle.
    assign in_ready = !m_valid || out_ready;

    // Single entry: a new input replaces the departing one with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ctrl  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (xfer_in) begin
            m_valid <= 1'b1;
            m_data  <= in_data;
            m_ctrl  <= in_ctrl;
        end else if (xfer_out) begin
            m_valid <= 1'b0;
        end
    end
`endif

    // Back-pressure counter: survives flush, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (m_valid && !out_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: two instances (16-bit and 4-bit
// stall counters) share stimulus and are compared each cycle against a
// queue-based model, plus hand-computed literal expectations.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic [15:0] in_ctrl;
    logic        out_ready;

    logic        in_ready_a,  out_valid_a;
    logic [31:0] out_data_a;
    logic [15:0] out_ctrl_a;
    logic [15:0] stall_cnt_a;

    logic        in_ready_b,  out_valid_b;
    logic [31:0] out_data_b;
    logic [15:0] out_ctrl_b;
    logic [3:0]  stall_cnt_b;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [31:0] d;
        logic [15:0] c;
    } ent_t;

    ent_t        q[$];
    logic [31:0] last_data;
    int          cnt_a;
    int          cnt_b;

`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_ctrl(out_ctrl_a),
        .stall_cnt(stall_cnt_a)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_ctrl(out_ctrl_b),
        .stall_cnt(stall_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: ready rule from occupancy and downstream state.
    function automatic logic model_ready(input logic orr);
        if (CAP == 1) return (q.size() == 0) || orr;
        return q.size() < 2;
    endfunction

    task automatic model_clear();
        q.delete();
        last_data = '0;
        cnt_a = 0;
        cnt_b = 0;
    endtask

    task automatic compare_all(input logic orr);
        logic        exp_v;
        logic [15:0] exp_c;
        exp_v = (q.size() > 0);
        exp_c = exp_v ? q[0].c : 16'h0;
        check("in_ready_a",  {63'd0, in_ready_a},  {63'd0, model_ready(orr)});
        check("out_valid_a", {63'd0, out_valid_a}, {63'd0, exp_v});
        check("out_ctrl_a",  {48'd0, out_ctrl_a},  {48'd0, exp_c});
        check("out_data_a",  {32'd0, out_data_a},  {32'd0, last_data});
        check("stall_cnt_a", {48'd0, stall_cnt_a}, 64'(cnt_a));
        check("in_ready_b",  {63'd0, in_ready_b},  {63'd0, model_ready(orr)});
        check("out_valid_b", {63'd0, out_valid_b}, {63'd0, exp_v});
        check("out_ctrl_b",  {48'd0, out_ctrl_b},  {48'd0, exp_c});
        check("out_data_b",  {32'd0, out_data_b},  {32'd0, last_data});
        check("stall_cnt_b", {60'd0, stall_cnt_b}, 64'(cnt_b));
    endtask

    task automatic model_edge(input logic iv, input logic [31:0] d, input logic [15:0] c,
                              input logic orr, input logic fl);
        logic acc;
        ent_t e;
        acc = iv && model_ready(orr) && !fl;
        if (q.size() > 0 && !orr) begin
            cnt_a = (cnt_a < 65535) ? cnt_a + 1 : 65535;
            cnt_b = (cnt_b < 15) ? cnt_b + 1 : 15;
        end
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && orr) void'(q.pop_front());
            if (acc) begin
                e.d = d;
                e.c = c;
                q.push_back(e);
            end
        end
        if (q.size() > 0) last_data = q[0].d;
    endtask

    // One clock: drive, check current outputs, advance model, cross the edge.
    task automatic step(input logic iv, input logic [31:0] d, input logic [15:0] c,
                        input logic orr, input logic fl);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = orr;
        flush     = fl;
        #1;
        compare_all(orr);
        model_edge(iv, d, c, orr, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b1;
        in_data   = 32'h10;
        in_ctrl   = 16'hFFFF;
        out_ready = 1'b1;
        flush     = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", {63'd0, out_valid_a}, 64'd0);
        check("rst_out_ctrl",  {48'd0, out_ctrl_a},  64'd0);
        check("rst_out_data",  {32'd0, out_data_a},  64'd0);
        check("rst_stall_cnt", {48'd0, stall_cnt_a}, 64'd0);
        check("rst_in_ready",  {63'd0, in_ready_a},  64'd1);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_valid", {63'd0, out_valid_a}, 64'd0);
        check("rst_hold_ctrl",  {48'd0, out_ctrl_b},  64'd0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_ctrl = '0;
        out_ready = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // Stream, reset mid-stream, then stream 0x10..0x12.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + i, 16'h0011, 1'b1, 1'b0);
        do_reset();
        step(1'b1, 32'h10, 16'h0010, 1'b1, 1'b0);
        check("stream0_data",  {32'd0, out_data_a}, 64'h10);
        check("stream0_valid", {63'd0, out_valid_a}, 64'd1);
        step(1'b1, 32'h11, 16'h0011, 1'b1, 1'b0);
        check("stream1_data",  {32'd0, out_data_a}, 64'h11);
        step(1'b1, 32'h12, 16'h0012, 1'b1, 1'b0);
        check("stream2_data",  {32'd0, out_data_a}, 64'h12);
        check("stream2_ctrl",  {48'd0, out_ctrl_a}, 64'h12);
        check("stream_cnt",    {48'd0, stall_cnt_a}, 64'd0);

        // Back-pressure: 0xA5 held for 5 stalled cycles, 0xA6 offered.
        do_reset();
        step(1'b1, 32'hA5, 16'h0003, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 32'hA6, 16'h0004, 1'b0, 1'b0);
        check("bp_hold_data", {32'd0, out_data_a}, 64'hA5);
        check("bp_stall_cnt", {48'd0, stall_cnt_a}, 64'd5);
        check("bp_in_ready",  {63'd0, in_ready_a}, 64'd0);
        step(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
        check("bp_second_data",  {32'd0, out_data_a}, 64'hA6);
        check("bp_second_valid", {63'd0, out_valid_a}, 64'd1);
`else
        check("bp_drain_valid", {63'd0, out_valid_a}, 64'd0);
        check("bp_drain_data",  {32'd0, out_data_a}, 64'hA5);
`endif
        step(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        check("bp_empty_valid", {63'd0, out_valid_a}, 64'd0);

        // Flush with entries held and an all-ones control input.
        do_reset();
        step(1'b1, 32'h21, 16'h0001, 1'b0, 1'b0);
        step(1'b1, 32'h22, 16'h0002, 1'b0, 1'b0);
        step(1'b1, 32'h55, 16'hFFFF, 1'b1, 1'b1);
        check("flush_valid", {63'd0, out_valid_a}, 64'd0);
        check("flush_ctrl",  {48'd0, out_ctrl_a},  64'd0);
        check("flush_data",  {32'd0, out_data_a},  64'h21);
        step(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        check("flush_gone",  {63'd0, out_valid_a}, 64'd0);

        // Saturation: 20 stalled cycles.
        do_reset();
        step(1'b1, 32'h31, 16'h0001, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        check("sat_cnt4",  {60'd0, stall_cnt_b}, 64'd15);
        check("sat_cnt16", {48'd0, stall_cnt_a}, 64'd20);

        // Bubble: data retained, control forced to zero.
        do_reset();
        step(1'b1, 32'h77, 16'h00F0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 16'h1234, 1'b1, 1'b0);
        check("bubble_valid", {63'd0, out_valid_a}, 64'd0);
        check("bubble_ctrl",  {48'd0, out_ctrl_a},  64'd0);
        check("bubble_data",  {32'd0, out_data_a},  64'h77);

        // Randomized traffic with one reset in the middle.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) do_reset();
            step($urandom_range(0, 3) != 0, $urandom, 16'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
